apb3_requester_arbiter: RTL and testbench
=========================================

# apb3_requester_arbiter

Shares one APB3 completer between `NUM_REQ` internal requesters. Each requester presents a single-beat read or write on a simple valid/ready port. The block arbitrates round-robin, sequences the APB3 IDLE/SETUP/ACCESS phases, waits for `PREADY`, and returns read data and error status to the granted requester. It sits between the system's bus masters and the APB3 RAM completer.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 32: APB address width.
- `DATA_WIDTH`, 32: APB data width.
- `TIMEOUT_CYCLES`, 16: ACCESS-phase wait limit; used only with the timeout feature, 2..255.

Ports:
- `PCLK` in 1: the single clock; all logic is on its rising edge.
- `PRESET` in 1: reset, synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester transfer request.
- `req_write` in NUM_REQ: per-requester direction (1 = write).
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed addresses; requester i uses slice i.
- `req_wdata` in NUM_REQ*DATA_WIDTH: packed write data; requester i uses slice i.
- `req_ready` out NUM_REQ: one-hot, one-cycle grant/accept pulse.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle completion pulse.
- `rsp_rdata` out DATA_WIDTH: read data, valid with `rsp_valid`.
- `rsp_err` out 1: completion error, valid with `rsp_valid`.
- `PADDR` out ADDR_WIDTH, `PSEL` out 1, `PENABLE` out 1, `PWRITE` out 1, `PWDATA` out DATA_WIDTH: APB3 requester outputs, all registered.
- `PRDATA` in DATA_WIDTH, `PREADY` in 1, `PSLVERR` in 1: APB3 completer responses.
- `busy` out 1: high when the state is not IDLE.

## Operation
- States are IDLE, SETUP and ACCESS.
- **IDLE**
  - If any `req_valid` is high, select the winner round-robin. Search starts at `(last_grant+1) mod NUM_REQ`.
  - Latch the winner's addr, write and wdata; update `last_grant`; go to SETUP.
  - If no request is pending, stay in IDLE.
- **SETUP**
  - `PSEL`=1, `PENABLE`=0; `req_ready[g]`=1 for this cycle only.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - `PSEL`=1, `PENABLE`=1. All APB outputs are held stable.
  - When `PREADY` is sampled high, capture `PRDATA` and `PSLVERR` and go to IDLE.
  - In that IDLE cycle, drive `rsp_valid[g]`=1, `rsp_rdata` = captured data and `rsp_err` = captured `PSLVERR`.
- A write completion returns `rsp_rdata`=0.
- `PWDATA` carries the latched wdata for reads as well; the completer ignores it.
- The requester holds its fields stable while `req_valid` is high. Fields are sampled only at the arbitration edge.
- If `req_valid` drops before a grant, nothing is issued.
- Completer errors (e.g. an out-of-range address on the RAM) are passed through unmodified on `rsp_err`.
- Reset values:
  - `PSEL`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA` = 0.
  - `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `busy` = 0.
  - State = IDLE; `last_grant` = NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-transfer: the transfer is abandoned. `PSEL`/`PENABLE` are 0 in the cycle after the reset edge, and no `rsp_valid` is issued.

## Timing
- Cycle 0: `req_valid[i]` high in IDLE.
- Cycle 1: SETUP; `req_ready[i]` pulse.
- Cycle 2: ACCESS.
- If `PREADY`=1 in cycle 2, `rsp_valid[i]` pulses in cycle 3. Cycle 3 is IDLE and arbitrates again.
- Minimum 3 cycles per transfer. Each `PREADY`-low ACCESS cycle adds one.
- `rsp_valid` for transfer n and the arbitration for transfer n+1 happen in the same cycle.
- `PSEL` drops for exactly one cycle between back-to-back transfers.

## Configuration
- Macro `APB_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on SETUP entry and increments on each ACCESS cycle with `PREADY`=0.
  - When it reaches `TIMEOUT_CYCLES`, the transfer aborts: go to IDLE, and `PSEL`/`PENABLE` are 0 the next cycle.
  - The requester then gets `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0.
  - A `PREADY` in the same cycle as the limit wins: normal completion.
- **Undefined:** ACCESS waits indefinitely, `TIMEOUT_CYCLES` is ignored, and no counter is synthesized.

## Test plan
- Single write then read: req 0 writes 0xDEADBEEF to addr 5, then reads addr 5, with `PREADY` high in ACCESS.
  - Required: `req_ready[0]` in cycle 1 and `rsp_valid[0]` in cycle 3 of each transfer.
  - Required: the read returns `rsp_rdata`=0xDEADBEEF with `rsp_err`=0.
- Round-robin: all four `req_valid` held high from reset.
  - Required: grant order 0,1,2,3,0.
  - Required: `PSEL` low exactly one cycle between transfers, with no requester starved.
- Wait states: `PREADY` held low for 3 ACCESS cycles on a read of addr 2.
  - Required: PADDR/PWRITE/PENABLE stable throughout.
  - Required: `rsp_valid` arrives 3 cycles later than the zero-wait case.
- Error pass-through: read addr 40.
  - Required: completer `PSLVERR`=1 gives `rsp_err`=1 on the requester's response.
- Reset mid-ACCESS: assert `PRESET` for 1 cycle during a `PREADY`-low ACCESS.
  - Required: `PSEL`=0 next cycle, no `rsp_valid`, and requester 0 wins the next arbitration.
- Timeout (`APB_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): `PREADY` held 0.
  - Required: abort after 4 ACCESS cycles, with `rsp_err`=1 and `rsp_rdata`=0.
  - Without the macro: transfer still pending after 100 cycles.

Source files
------------

// File: rtl/apb3_requester_arbiter.sv
// apb3_requester_arbiter: round-robin sharing of one APB3 completer by NUM_REQ requesters.
// Optional: define APB_ARB_TIMEOUT_EN to abort ACCESS phases longer than TIMEOUT_CYCLES.
module apb3_requester_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                          PCLK,
   input  logic                          PRESET,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_err,
   output logic [ADDR_WIDTH-1:0]         PADDR,
   output logic                          PSEL,
   output logic                          PENABLE,
   output logic                          PWRITE,
   output logic [DATA_WIDTH-1:0]         PWDATA,
   input  logic [DATA_WIDTH-1:0]         PRDATA,
   input  logic                          PREADY,
   input  logic                          PSLVERR,
   output logic                          busy
);

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_e;

   state_e                 state_q, state_d;
   logic [GW-1:0]          last_q, last_d;
   logic [GW-1:0]          gnt_q, gnt_d;
   logic                   psel_q, psel_d;
   logic                   penable_q, penable_d;
   logic                   pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
   logic [NUM_REQ-1:0]     ready_q, ready_d;
   logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic                   rsp_err_q, rsp_err_d;

`ifdef APB_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
   logic [7:0]             cnt_q, cnt_d;
`endif

   logic                   found;
   logic [GW-1:0]          win;
   logic                   sel_write;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [DATA_WIDTH-1:0]  sel_wdata;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      int idx;
      found     = 1'b0;
      win       = '0;
      idx       = 0;
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_q) + k) % NUM_REQ;
         if (!found && req_valid[GW'(idx)]) begin
            found = 1'b1;
            win   = GW'(idx);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (GW'(i) == win) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gnt_d       = gnt_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      ready_d     = '0;
      rsp_valid_d = '0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (found) begin
               state_d      = S_SETUP;
               last_d       = win;
               gnt_d        = win;
               psel_d       = 1'b1;
               pwrite_d     = sel_write;
               paddr_d      = sel_addr;
               pwdata_d     = sel_wdata;
               ready_d[win] = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
               cnt_d        = '0;
`endif
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            state_d   = S_ACCESS;
         end
         S_ACCESS: begin
            if (PREADY) begin
               state_d            = S_IDLE;
               psel_d             = 1'b0;
               penable_d          = 1'b0;
               rsp_valid_d[gnt_q] = 1'b1;
               rsp_rdata_d        = pwrite_q ? '0 : PRDATA;
               rsp_err_d          = PSLVERR;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (cnt_q + 8'd1 == TO_LIM) begin
               state_d            = S_IDLE;
               psel_d             = 1'b0;
               penable_d          = 1'b0;
               rsp_valid_d[gnt_q] = 1'b1;
               rsp_err_d          = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         default: begin
            state_d   = S_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= S_IDLE;
         last_q      <= GW'(NUM_REQ - 1);
         gnt_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         ready_q     <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef APB_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_apb3_requester_arbiter.sv
// tb_apb3_requester_arbiter: directed bench with a small APB RAM completer (32 words).
// Timeout expectations follow APB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 4.
module tb_apb3_requester_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            PCLK = 1'b0;
   logic            PRESET;
   logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_err;
   logic [AW-1:0]   PADDR;
   logic            PSEL, PENABLE, PWRITE;
   logic [DW-1:0]   PWDATA, PRDATA;
   logic            PREADY, PSLVERR, busy;

   int checks = 0;
   int errors = 0;
   bit stall = 1'b0;
   int wait_states = 0;
   int acc_cnt = 0;
   bit [31:0] mem [32];

   always #5 PCLK = ~PCLK;

   apb3_requester_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .busy(busy)
   );

   // Completer: inserts wait_states low-PREADY cycles, errors above word 31.
   assign PREADY  = PSEL && PENABLE && !stall && (acc_cnt >= wait_states);
   assign PSLVERR = PREADY && (PADDR >= 32);
   assign PRDATA  = (PADDR < 32) ? mem[PADDR[4:0]] : '0;

   always @(posedge PCLK) begin
      if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (PREADY && PWRITE && PADDR < 32) mem[PADDR[4:0]] <= PWDATA;
   end

   task automatic tick;
      @(posedge PCLK);
      #1;
   endtask

   task automatic set_req(input int r, input bit w,
                          input logic [31:0] a, input logic [31:0] d);
      req_write[r]          = w;
      req_addr[r*AW +: AW]  = a;
      req_wdata[r*DW +: DW] = d;
      req_valid[r]          = 1'b1;
   endtask

   task automatic drain;
      for (int i = 0; i < 30 && busy; i++) tick;
      tick;
   endtask

   // Issues one transfer from the current (IDLE) cycle, which is cycle 0.
   task automatic run_xfer(input int r, input bit w,
                           input logic [31:0] a, input logic [31:0] d,
                           output int rdy_cyc, output int rsp_cyc,
                           output logic [31:0] rd, output logic er);
      rdy_cyc = -1;
      rsp_cyc = -1;
      rd      = 'x;
      er      = 1'bx;
      set_req(r, w, a, d);
      for (int k = 1; k <= 50; k++) begin
         tick;
         if (req_ready[r] && rdy_cyc < 0) begin
            rdy_cyc      = k;
            req_valid[r] = 1'b0;
         end
         if (rsp_valid[r]) begin
            rsp_cyc = k;
            rd      = rsp_rdata;
            er      = rsp_err;
            break;
         end
      end
      req_valid[r] = 1'b0;
   endtask

   task automatic test_reset;
      PRESET    = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      tick;
      tick;
      checks++;
      if ({PSEL, PENABLE, PWRITE, req_ready, rsp_valid, rsp_err, busy} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 0",
                  {PSEL, PENABLE, PWRITE, req_ready, rsp_valid, rsp_err, busy});
      end
      checks++;
      if ((PADDR | PWDATA | rsp_rdata) !== '0) begin
         errors++;
         $display("FAIL reset_data: PADDR %h PWDATA %h rdata %h want 0",
                  PADDR, PWDATA, rsp_rdata);
      end
      PRESET = 1'b0;
      tick;
   endtask

   task automatic test_write_read;
      int rc, sc;
      logic [31:0] rd;
      logic er;
      run_xfer(0, 1'b1, 32'd5, 32'hDEADBEEF, rc, sc, rd, er);
      checks++;
      if (rc !== 1 || sc !== 3) begin
         errors++;
         $display("FAIL wr_timing: ready %0d rsp %0d want 1 3", rc, sc);
      end
      checks++;
      if (rd !== 32'h0 || er !== 1'b0) begin
         errors++;
         $display("FAIL wr_rsp: rdata %h err %b want 0 0", rd, er);
      end
      run_xfer(0, 1'b0, 32'd5, 32'h0, rc, sc, rd, er);
      checks++;
      if (rc !== 1 || sc !== 3) begin
         errors++;
         $display("FAIL rd_timing: ready %0d rsp %0d want 1 3", rc, sc);
      end
      checks++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
         errors++;
         $display("FAIL rd_rsp: rdata %h err %b want deadbeef 0", rd, er);
      end
   endtask

   task automatic test_round_robin;
      int gq[$];
      int cq[$];
      int gaps[$];
      int low_run;
      bit started;
      int exp_g [5] = '{0, 1, 2, 3, 0};
      int exp_c [5] = '{1, 4, 7, 10, 13};
      PRESET = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'(i), 32'h0);
      tick;
      PRESET  = 1'b0;
      low_run = 0;
      started = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tick;
         for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
               gq.push_back(i);
               cq.push_back(k);
            end
         end
         if (PSEL) begin
            if (started && low_run > 0) gaps.push_back(low_run);
            started = 1'b1;
            low_run = 0;
         end else if (started) begin
            low_run++;
         end
      end
      req_valid = '0;
      checks++;
      if (gq.size() !== 5) begin
         errors++;
         $display("FAIL rr_count: got %0d grants want 5", gq.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (gq[i] !== exp_g[i] || cq[i] !== exp_c[i]) begin
               errors++;
               $display("FAIL rr_grant%0d: req %0d cyc %0d want %0d %0d",
                        i, gq[i], cq[i], exp_g[i], exp_c[i]);
            end
         end
      end
      checks++;
      if (gaps.size() !== 4) begin
         errors++;
         $display("FAIL rr_gaps: got %0d gaps want 4", gaps.size());
      end
      foreach (gaps[i]) begin
         checks++;
         if (gaps[i] !== 1) begin
            errors++;
            $display("FAIL rr_gap%0d: PSEL low %0d cycles want 1", i, gaps[i]);
         end
      end
      drain;
   endtask

   task automatic test_wait_states;
      int rc, sc, k;
      logic [31:0] rd;
      logic er;
      run_xfer(1, 1'b1, 32'd2, 32'hCAFE0002, rc, sc, rd, er);
      wait_states = 3;
      set_req(1, 1'b0, 32'd2, 32'h0);
      tick;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL ws_ready: got %b want 0010", req_ready);
      end
      req_valid[1] = 1'b0;
      k = 1;
      while (k < 20 && !rsp_valid[1]) begin
         tick;
         k++;
         if (!rsp_valid[1]) begin
            checks++;
            if ({PSEL, PENABLE, PWRITE} !== 3'b110 || PADDR !== 32'd2) begin
               errors++;
               $display("FAIL ws_stable: cyc %0d sel/en/wr %b addr %h want 110 2",
                        k, {PSEL, PENABLE, PWRITE}, PADDR);
            end
         end
      end
      checks++;
      if (k !== 6 || rsp_rdata !== 32'hCAFE0002) begin
         errors++;
         $display("FAIL ws_rsp: cyc %0d rdata %h want 6 cafe0002", k, rsp_rdata);
      end
      wait_states = 0;
   endtask

   task automatic test_error;
      int rc, sc;
      logic [31:0] rd;
      logic er;
      run_xfer(2, 1'b0, 32'd40, 32'h0, rc, sc, rd, er);
      checks++;
      if (sc !== 3 || er !== 1'b1) begin
         errors++;
         $display("FAIL err_pass: rsp %0d err %b want 3 1", sc, er);
      end
   endtask

   task automatic test_reset_mid;
      bit seen;
      stall = 1'b1;
      set_req(1, 1'b0, 32'd3, 32'h0);
      tick;
      req_valid[1] = 1'b0;
      tick;
      tick;
      checks++;
      if ({PSEL, PENABLE} !== 2'b11) begin
         errors++;
         $display("FAIL rm_access: sel/en %b want 11", {PSEL, PENABLE});
      end
      PRESET = 1'b1;
      tick;
      checks++;
      if ({PSEL, PENABLE, busy} !== 3'b000) begin
         errors++;
         $display("FAIL rm_abort: sel/en/busy %b want 000", {PSEL, PENABLE, busy});
      end
      PRESET = 1'b0;
      stall  = 1'b0;
      seen   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (rsp_valid !== '0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL rm_norsp: got rsp_valid after reset want none");
      end
      set_req(0, 1'b0, 32'd1, 32'h0);
      set_req(2, 1'b0, 32'd1, 32'h0);
      set_req(3, 1'b0, 32'd1, 32'h0);
      tick;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rm_first: ready %b want 0001", req_ready);
      end
      req_valid = '0;
      drain;
   endtask

   task automatic test_timeout;
`ifdef APB_ARB_TIMEOUT_EN
      int rc, sc;
      logic [31:0] rd;
      logic er;
      stall = 1'b1;
      run_xfer(3, 1'b0, 32'd7, 32'h0, rc, sc, rd, er);
      stall = 1'b0;
      checks++;
      if (rc !== 1 || sc !== 6) begin
         errors++;
         $display("FAIL to_timing: ready %0d rsp %0d want 1 6", rc, sc);
      end
      checks++;
      if (rd !== 32'h0 || er !== 1'b1) begin
         errors++;
         $display("FAIL to_rsp: rdata %h err %b want 0 1", rd, er);
      end
      tick;
      checks++;
      if ({PSEL, PENABLE} !== 2'b00) begin
         errors++;
         $display("FAIL to_idle: sel/en %b want 00", {PSEL, PENABLE});
      end
`else
      bit seen;
      stall = 1'b1;
      seen  = 1'b0;
      set_req(3, 1'b0, 32'd7, 32'h0);
      for (int k = 1; k <= 100; k++) begin
         tick;
         if (req_ready[3]) req_valid[3] = 1'b0;
         if (rsp_valid !== '0) seen = 1'b1;
      end
      req_valid = '0;
      checks++;
      if (seen || {busy, PSEL, PENABLE} !== 3'b111) begin
         errors++;
         $display("FAIL to_pending: rsp seen %b busy/sel/en %b want 0 111",
                  seen, {busy, PSEL, PENABLE});
      end
      PRESET = 1'b1;
      tick;
      PRESET = 1'b0;
      stall  = 1'b0;
      tick;
`endif
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_round_robin;
      test_wait_states;
      test_error;
      test_reset_mid;
      test_timeout;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
